key_voice_arbiter: RTL and testbench
====================================

# key_voice_arbiter

Shares the single-voice tone generator among all PS/2 keys currently held. Consumes the raw scancode byte stream (make, `F0` break and `E0` extended prefixes) and keeps an ordered stack of held keys. Drives the generator's `note_select` with the most recently pressed key still held (last-note priority), or steps through the held keys as an arpeggio when configured. Sits between the PS/2 receiver and the note/tone generator.

## Interface
- `DEPTH`, 4: number of held-key slots in the stack (2..8).
- `ARP_DIV`, 12_500_000: clock cycles per arpeggio step (250 ms at 50 MHz). Only used with the arpeggiator.

- `clock`  in  1  system clock; everything is sampled on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `ps2_key_data`  in  8  received scancode byte. Valid only while `ps2_key_pressed` is high.
- `ps2_key_pressed`  in  1  one-cycle strobe per received byte.
- `note_select`  out  8  scancode of the selected voice; `8'h00` when nothing is held.
- `note_valid`  out  1  high when at least one key is held.
- `held_count`  out  $clog2(DEPTH+1)  number of occupied slots.
- `overflow`  out  1  one-cycle pulse when a push evicts the oldest entry.

## Operation
- Bytes are only examined on cycles where `ps2_key_pressed`=1; all other cycles leave the parser and stack unchanged.
- Parser FSM has four states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: `F0` goes to BRK; `E0` goes to EXT; a byte with bit7=0 is a make event, stays in IDLE; any other byte (`AA`, `FA`, `FE`, ...) is ignored, stays in IDLE.
  - BRK: the byte is a break event for that code; return to IDLE.
  - EXT: `F0` goes to EXT_BRK; any other byte is discarded and returns to IDLE.
  - EXT_BRK: the byte is discarded; return to IDLE.
  - Extended keys never touch the stack.
- Make event, stack update:
  - Code already present: no change (typematic repeat ignored), no overflow.
  - Code absent and count<DEPTH: push on top, count+1.
  - Code absent and count=DEPTH: drop the oldest entry, shift the rest down, push on top, pulse `overflow`, count unchanged.
- Break event: remove the matching entry and compact the entries above it downward, preserving their order, count−1. If the code is absent, no change.
- `note_select` is the top entry; `note_valid` = (count≠0); `note_select`=`8'h00` when empty.
- The stack holds unique codes only. A code of `8'h00` is never pushed (treated as ignored).

## Timing
- All outputs are registered. `note_select`, `note_valid` and `held_count` update one cycle after the strobe carrying the final byte of a make/break. `overflow` is high in that same cycle for exactly one cycle.
- Prefix bytes cause no output change.
- Reset value of every output: `note_select`=00, `note_valid`=0, `held_count`=0, `overflow`=0. Reset also returns the parser to IDLE, clears all slots, and zeroes the arpeggio index and counter.
- `reset` overrides a coincident strobe; that byte is lost.
- Reset arriving mid-sequence (e.g. after `F0`) discards the pending prefix.
- Back-to-back strobes on consecutive cycles must be processed without loss.

## Configuration
- `KEY_VOICE_ARP_EN`, when defined:
  - With count≥2, `note_select` steps through the stack oldest→newest, advancing every `ARP_DIV` cycles and wrapping to the oldest after the newest.
  - Any stack change resets the step index to the oldest entry and restarts the divider.
  - With count=1, the output is that entry, as without the macro.
- When not defined: no divider or index logic exists; `note_select` is always the top entry.

## Structure
- Package `key_voice_pkg` holds:
  - constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `NOTE_NONE`=8'h00;
  - the parser state enum.
- Sub-module `ps2_prefix_parser` contains the FSM. It outputs `make_strb`, `break_strb` (one cycle each) and `code[7:0]`.
- The top level holds the stack, compaction logic, output registers and the optional arpeggiator.

## Test plan
- After reset, stream `1C`: next cycle `note_select`=1C, `note_valid`=1, `held_count`=1.
- Stream `1C`,`1A`,`F0 1A`: `note_select` goes 1C→1A→1C; count goes 1→2→1.
- DEPTH=4. Press `15 1D 24 2D 2C`: on `2C`, `overflow` pulses one cycle, `note_select`=2C, `held_count`=4. A later `F0 15` leaves the count at 4 (15 was evicted).
- Stream `E0 75`, `E0 F0 75`, then `AA`: the stack is unchanged throughout, `note_valid`=0.
- Stream `F0`, assert `reset`, then `1C`: the result is a make of 1C (`note_select`=1C), not a break.
- With `KEY_VOICE_ARP_EN` and ARP_DIV=4, hold `15 1D 24`: `note_select` cycles 15,1D,24,15 every 4 cycles. A `F0 1D` restarts the sequence at 15.

Source files
------------

// File: rtl/key_voice_pkg.sv
// Shared constants and parser state encoding for the PS/2 key voice arbiter.
package key_voice_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] NOTE_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } parser_state_t;

endpackage

// File: rtl/ps2_prefix_parser.sv
// Tracks F0/E0 prefixes and flags make/break events of non-extended keys.
// Strobes are decoded from the registered state so the event is seen on the strobe cycle.
module ps2_prefix_parser
  import key_voice_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       make_strb,
  output logic       break_strb,
  output logic [7:0] code
);

  parser_state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else if (ps2_key_pressed) begin
      case (state)
        IDLE: begin
          if (ps2_key_data == PS2_BREAK)    state <= BRK;
          else if (ps2_key_data == PS2_EXT) state <= EXT;
          else                              state <= IDLE;
        end
        EXT:     state <= (ps2_key_data == PS2_BREAK) ? EXT_BRK : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A zero code never names a real key, so it is never reported as a make.
  always_comb begin
    make_strb  = ps2_key_pressed && (state == IDLE) && !ps2_key_data[7] &&
                 (ps2_key_data != NOTE_NONE);
    break_strb = ps2_key_pressed && (state == BRK);
    code       = ps2_key_data;
  end

endmodule

// File: rtl/key_voice_arbiter.sv
// Last-note-priority stack of held PS/2 keys driving a single-voice tone generator.
// Optional arpeggiator over the held keys when KEY_VOICE_ARP_EN is defined.
module key_voice_arbiter
  import key_voice_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ARP_DIV = 12_500_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 ps2_key_data,
  input  logic                       ps2_key_pressed,
  output logic [7:0]                 note_select,
  output logic                       note_valid,
  output logic [$clog2(DEPTH+1)-1:0] held_count,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 8 || ARP_DIV < 1) begin : g_bad_param
    $error("key_voice_arbiter: DEPTH must be 2..8 and ARP_DIV positive");
  end

  logic          make_strb, break_strb;
  logic [7:0]    code;
  logic [7:0]    stack [DEPTH];
  logic [7:0]    stack_nxt [DEPTH];
  logic [CW-1:0] count, count_nxt;
  logic          ovf_nxt, hit;
  int            hit_idx;
  logic [7:0]    top_nxt, note_nxt;

  ps2_prefix_parser u_parser (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .make_strb       (make_strb),
    .break_strb      (break_strb),
    .code            (code)
  );

  // Slot 0 is the oldest key, slot count-1 the newest; unused slots stay zero.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && CW'(i) < count && stack[i] == code) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end

    stack_nxt = stack;
    count_nxt = count;
    ovf_nxt   = 1'b0;
    if (make_strb && !hit) begin
      if (count == CW'(DEPTH)) begin
        for (int i = 0; i < DEPTH - 1; i++) stack_nxt[i] = stack[i+1];
        stack_nxt[DEPTH-1] = code;
        ovf_nxt            = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == count) stack_nxt[i] = code;
        end
        count_nxt = count + CW'(1);
      end
    end else if (break_strb && hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= hit_idx) stack_nxt[i] = stack[i+1];
      end
      stack_nxt[DEPTH-1] = NOTE_NONE;
      count_nxt          = count - CW'(1);
    end

    top_nxt = NOTE_NONE;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count_nxt) top_nxt = stack_nxt[i];
    end
  end

`ifdef KEY_VOICE_ARP_EN
  localparam logic [31:0] ARP_LAST = 32'(ARP_DIV - 1);

  logic [CW-1:0] arp_idx, arp_idx_nxt;
  logic [31:0]   arp_cnt, arp_cnt_nxt;
  logic          changed;

  // Any push, eviction or removal restarts the sequence at the oldest key.
  always_comb begin
    changed     = (count_nxt != count) || ovf_nxt;
    arp_idx_nxt = '0;
    arp_cnt_nxt = '0;
    if (!changed && count >= CW'(2)) begin
      if (arp_cnt == ARP_LAST) begin
        arp_idx_nxt = (arp_idx == count - CW'(1)) ? '0 : arp_idx + CW'(1);
      end else begin
        arp_idx_nxt = arp_idx;
        arp_cnt_nxt = arp_cnt + 32'd1;
      end
    end
    note_nxt = top_nxt;
    if (count_nxt >= CW'(2)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == arp_idx_nxt) note_nxt = stack_nxt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      arp_idx <= '0;
      arp_cnt <= '0;
    end else begin
      arp_idx <= arp_idx_nxt;
      arp_cnt <= arp_cnt_nxt;
    end
  end
`else
  assign note_nxt = top_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= NOTE_NONE;
      count       <= '0;
      note_select <= NOTE_NONE;
      note_valid  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      stack       <= stack_nxt;
      count       <= count_nxt;
      note_select <= note_nxt;
      note_valid  <= (count_nxt != '0);
      overflow    <= ovf_nxt;
    end
  end

  assign held_count = count;

endmodule

// File: tb/tb_key_voice_arbiter.sv
// Scoreboard bench for key_voice_arbiter (default build, last-note priority, DEPTH=4).
module tb_key_voice_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    ps2_key_data;
  logic          ps2_key_pressed;
  logic [7:0]    note_select;
  logic          note_valid;
  logic [CW-1:0] held_count;
  logic          overflow;

  key_voice_arbiter #(.DEPTH(DEPTH), .ARP_DIV(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .note_select     (note_select),
    .note_valid      (note_valid),
    .held_count      (held_count),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] note;
    logic       valid;
    int         cnt;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Reference model: held keys in press order, plus pending prefix (0 none, 1 F0, 2 E0, 3 E0 F0).
  logic [7:0] held[$];
  int         pmode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  task automatic model_byte(input logic [7:0] b, output logic ovf);
    int idx;
    ovf = 1'b0;
    idx = -1;
    foreach (held[i]) if (held[i] == b) idx = i;
    case (pmode)
      0: begin
        if (b == 8'hF0) pmode = 1;
        else if (b == 8'hE0) pmode = 2;
        else if (b < 8'h80 && b != 8'h00 && idx < 0) begin
          held.push_back(b);
          if (held.size() > DEPTH) begin
            void'(held.pop_front());
            ovf = 1'b1;
          end
        end
      end
      1: begin
        if (idx >= 0) held.delete(idx);
        pmode = 0;
      end
      2: pmode = (b == 8'hF0) ? 3 : 0;
      default: pmode = 0;
    endcase
  endtask

  task automatic drive(input logic [7:0] b);
    exp_t e;
    logic ovf;
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    model_byte(b, ovf);
    e.note  = (held.size() != 0) ? held[held.size()-1] : 8'h00;
    e.valid = (held.size() != 0);
    e.cnt   = held.size();
    e.ovf   = ovf;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    ps2_key_pressed = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_state();
    check("reset_note", 32'(note_select), 32'h00);
    check("reset_valid", 32'(note_valid), 32'h0);
    check("reset_count", 32'(held_count), 32'h0);
    check("reset_ovf", 32'(overflow), 32'h0);
  endtask

  // Optional coincident byte is dropped by reset.
  task automatic do_reset(input logic with_byte, input logic [7:0] b);
    reset           = 1'b1;
    ps2_key_data    = b;
    ps2_key_pressed = with_byte;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    held.delete();
    pmode = 0;
    check_reset_state();
    reset = 1'b0;
  endtask

  // Monitor: after every accepted strobe, the next cycle must show the queued result.
  initial begin
    logic p, r;
    exp_t e;
    forever begin
      @(posedge clock);
      p = ps2_key_pressed && !reset;
      r = reset;
      @(negedge clock);
      if (p) begin
        if (exp_q.size() == 0) begin
          check("unexpected_update", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("note_select", 32'(note_select), 32'(e.note));
          check("note_valid", 32'(note_valid), 32'(e.valid));
          check("held_count", 32'(held_count), 32'(e.cnt));
          check("overflow", 32'(overflow), 32'(e.ovf));
        end
      end else if (!r) begin
        check("overflow_idle", 32'(overflow), 32'h0);
      end
    end
  end

  logic [7:0] pool [12] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h1C,
                           8'h1A, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'h00};

  initial begin
    reset           = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_state();
    reset = 1'b0;

    drive(8'h1C); idle(2);
    drive(8'h1A); idle(1);
    drive(8'hF0); drive(8'h1A); idle(1);
    drive(8'h1C); idle(1);
    drive(8'hF0); drive(8'h1C); idle(1);

    drive(8'h15); drive(8'h1D); drive(8'h24); drive(8'h2D); drive(8'h2C); idle(1);
    drive(8'hF0); drive(8'h15); idle(1);
    drive(8'hF0); drive(8'h2D); drive(8'h1D); idle(1);

    drive(8'hE0); drive(8'h75); drive(8'hE0); drive(8'hF0); drive(8'h75); drive(8'hAA);
    idle(1);
    drive(8'hF0); drive(8'h1D); drive(8'hF0); drive(8'h24); drive(8'hF0); drive(8'h2C);
    idle(1);
    drive(8'hE0); drive(8'h75); drive(8'hAA); idle(1);

    drive(8'h1A); drive(8'hF0); idle(1);
    do_reset(1'b0, 8'h00);
    drive(8'h1C); idle(1);
    do_reset(1'b1, 8'h1A);
    drive(8'h24); idle(1);

    for (int k = 0; k < 400; k++) begin
      drive(pool[$urandom_range(0, 11)]);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(3);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
